// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory-stage load decoder and store encoder:
// size codes, the store FSM state encoding, lane-mask constants and the
// store alignment check.
// Lane numbering is big-endian: lane 3 is bits 31:24 (lowest byte address).
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_BYTE    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } sizeE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WRITE = 2'b11
    } stateE;

    localparam logic [3:0] LANE_NONE    = 4'b0000;
    localparam logic [3:0] LANE_ALL     = 4'b1111;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_BYTE0   = 4'b1000;

    // Misaligned half/word or the reserved size code.
    function automatic logic storeIllegal(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_WORD: return offset != 2'b00;
            SIZE_HALF: return offset[0];
            SIZE_BYTE: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge
// Combinational lane steering for stores.
//   size, offset : store size code and byte offset within the word
//   srcData      : store source register
//   oldWord      : word read back from memory (RMW)
//   mergedWord   : oldWord with the target lanes replaced by source data
//   replData     : source data replicated into every lane
//   laneMask     : target lanes, [3] = bits 31:24; 0000 for the reserved size
module store_lane_merge
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] srcData,
    input  logic [31:0] oldWord,
    output logic [31:0] mergedWord,
    output logic [31:0] replData,
    output logic [3:0]  laneMask
);

    always_comb begin
        laneMask = LANE_NONE;
        replData = srcData;
        case (size)
            SIZE_WORD: laneMask = LANE_ALL;
            SIZE_HALF: begin
                laneMask = offset[1] ? LANE_HALF_LO : LANE_HALF_HI;
                replData = {2{srcData[15:0]}};
            end
            SIZE_BYTE: begin
                laneMask = LANE_BYTE0 >> offset;
                replData = {4{srcData[7:0]}};
            end
            default: laneMask = LANE_NONE;
        endcase
    end

    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (laneMask[i])
                mergedWord[8*i +: 8] = replData[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_write_encoder.sv
// mem_write_encoder
// Converts MEM-stage store requests into word-wide data-memory writes,
// big-endian lane order. Sub-word stores are done as read-modify-write on a
// word-only memory; the pipeline is stalled until the write issues.
//   clk, rst_n        : clock, async active-low reset
//   st_req/addr/data  : store request, held stable until st_done/st_error
//   data_size         : 00 word, 01 half, 10 byte, 11 illegal
//   st_busy           : stall, st_done / st_error : one-cycle completion pulses
//   mem_*             : word address, read strobe/data, write strobe/data, lane enables
// Build option MEM_STORE_BYTE_EN_EN: memory has per-lane write enables, so
// every legal store is a single write with a lane mask and no read.
module mem_write_encoder
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  data_size,
    output logic        st_busy,
    output logic        st_done,
    output logic        st_error,
    output logic [29:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_byte_en
);

    stateE       state;
    logic [1:0]  cnt;
    logic [1:0]  latSize;
    logic [1:0]  latOff;
    logic [31:0] latData;
    logic [29:0] addrQ;
    logic        rdEnQ;
    logic        wrEnQ;
    logic        doneQ;
    logic [31:0] wrDataQ;

    logic        illegal;
    logic        accept;
    logic [1:0]  mergeSize;
    logic [1:0]  mergeOff;
    logic [31:0] mergeSrc;
    logic [31:0] mergedWord;
    logic [31:0] replData;
    logic [3:0]  laneMask;

    assign illegal  = storeIllegal(data_size, st_addr[1:0]);
    assign st_error = (state == ST_IDLE) & st_req & illegal;
    assign accept   = (state == ST_IDLE) & st_req & ~illegal;
    assign st_busy  = st_req & ~st_done & ~st_error;

    // In IDLE the merger looks at the live request so the accept cycle can
    // decide the path and latch write data; afterwards it uses latched copies.
    assign mergeSize = (state == ST_IDLE) ? data_size    : latSize;
    assign mergeOff  = (state == ST_IDLE) ? st_addr[1:0] : latOff;
    assign mergeSrc  = (state == ST_IDLE) ? st_data      : latData;

    store_lane_merge uMerge (
        .size       (mergeSize),
        .offset     (mergeOff),
        .srcData    (mergeSrc),
        .oldWord    (mem_rd_data),
        .mergedWord (mergedWord),
        .replData   (replData),
        .laneMask   (laneMask)
    );

`ifdef MEM_STORE_BYTE_EN_EN
    logic [3:0] byteEnQ;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            latSize <= '0;
            latOff  <= '0;
            latData <= '0;
            addrQ   <= '0;
            rdEnQ   <= 1'b0;
            wrEnQ   <= 1'b0;
            doneQ   <= 1'b0;
            wrDataQ <= '0;
`ifdef MEM_STORE_BYTE_EN_EN
            byteEnQ <= '0;
`endif
        end else begin
            rdEnQ <= 1'b0;
            wrEnQ <= 1'b0;
            doneQ <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        latSize <= data_size;
                        latOff  <= st_addr[1:0];
                        latData <= st_data;
                        addrQ   <= st_addr[31:2];
`ifdef MEM_STORE_BYTE_EN_EN
                        byteEnQ <= laneMask;
                        wrDataQ <= replData;
                        wrEnQ   <= 1'b1;
                        doneQ   <= 1'b1;
                        state   <= ST_WRITE;
`else
                        // Full-word coverage needs no read of the old word.
                        if (laneMask == LANE_ALL) begin
                            wrDataQ <= replData;
                            wrEnQ   <= 1'b1;
                            doneQ   <= 1'b1;
                            state   <= ST_WRITE;
                        end else begin
                            rdEnQ <= 1'b1;
                            state <= ST_READ;
                        end
`endif
                    end
                end
                ST_READ: begin
                    cnt   <= 2'(READ_LATENCY - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        wrDataQ <= mergedWord;
                        wrEnQ   <= 1'b1;
                        doneQ   <= 1'b1;
                        state   <= ST_WRITE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr    = addrQ;
    assign mem_wr_en   = wrEnQ;
    assign mem_wr_data = wrDataQ;
    assign st_done     = doneQ;

`ifdef MEM_STORE_BYTE_EN_EN
    assign mem_rd_en   = 1'b0;
    assign mem_byte_en = byteEnQ;
`else
    assign mem_rd_en   = rdEnQ;
    assign mem_byte_en = LANE_ALL;
`endif

endmodule

// File: tb/tb_mem_write_encoder.sv
// tb_mem_write_encoder
// Directed bench for mem_write_encoder. Two instances share clock and reset:
// index 0 has READ_LATENCY=1, index 1 has READ_LATENCY=3. Each has its own
// word memory model with configurable read latency; reads outside the valid
// window return a poison pattern so a mistimed capture shows up in the data.
module tb_mem_write_encoder;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stReq[2];
    logic [31:0] stAddr[2];
    logic [31:0] stData[2];
    logic [1:0]  dataSize[2];
    logic        stBusy[2];
    logic        stDone[2];
    logic        stError[2];
    logic [29:0] memAddr[2];
    logic        memRdEn[2];
    logic [31:0] memRdData[2];
    logic        memWrEn[2];
    logic [31:0] memWrData[2];
    logic [3:0]  memByteEn[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_write_encoder #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rstN), .st_req(stReq[0]), .st_addr(stAddr[0]),
        .st_data(stData[0]), .data_size(dataSize[0]), .st_busy(stBusy[0]),
        .st_done(stDone[0]), .st_error(stError[0]), .mem_addr(memAddr[0]),
        .mem_rd_en(memRdEn[0]), .mem_rd_data(memRdData[0]), .mem_wr_en(memWrEn[0]),
        .mem_wr_data(memWrData[0]), .mem_byte_en(memByteEn[0])
    );

    mem_write_encoder #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rstN), .st_req(stReq[1]), .st_addr(stAddr[1]),
        .st_data(stData[1]), .data_size(dataSize[1]), .st_busy(stBusy[1]),
        .st_done(stDone[1]), .st_error(stError[1]), .mem_addr(memAddr[1]),
        .mem_rd_en(memRdEn[1]), .mem_rd_data(memRdData[1]), .mem_wr_en(memWrEn[1]),
        .mem_wr_data(memWrData[1]), .mem_byte_en(memByteEn[1])
    );

    // Memory models: 16 words each, preload port shared by both.
    logic [31:0] mem[2][16];
    logic [2:0]  rdV[2] = '{3'b000, 3'b000};
    logic [2:0][3:0] rdA[2];
    int          wrCnt[2] = '{0, 0};
    int          rdCnt[2] = '{0, 0};
    logic        preEn = 1'b0;
    logic [3:0]  preIdx = '0;
    logic [31:0] preVal = '0;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (preEn)
                mem[g][preIdx] <= preVal;
            else if (memWrEn[g])
                for (int i = 0; i < 4; i++)
                    if (memByteEn[g][i]) mem[g][memAddr[g][3:0]][8*i +: 8] <= memWrData[g][8*i +: 8];
            rdV[g] <= {rdV[g][1:0], memRdEn[g]};
            rdA[g] <= {rdA[g][1:0], memAddr[g][3:0]};
            if (memWrEn[g]) wrCnt[g] <= wrCnt[g] + 1;
            if (memRdEn[g]) rdCnt[g] <= rdCnt[g] + 1;
        end
    end

    assign memRdData[0] = rdV[0][0] ? mem[0][rdA[0][0]] : 32'hBAD0_BAD0;
    assign memRdData[1] = rdV[1][2] ? mem[1][rdA[1][2]] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        preEn = 1'b1; preIdx = idx; preVal = val;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    // Legal store: expN = negedges after the accept edge at which st_done is seen.
    task automatic storeOp(input int sel, input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size, input int expN,
                           input logic [31:0] expData, input logic [3:0] expBe, input int expRd);
        int n;
        int wr0;
        int rd0;
        logic seen;
        wr0 = wrCnt[sel];
        rd0 = rdCnt[sel];
        @(negedge clk);
        stAddr[sel] = addr; stData[sel] = data; dataSize[sel] = size; stReq[sel] = 1'b1;
        #1;
        check({tag, "_busy"}, 32'(stBusy[sel]), 32'd1);
        check({tag, "_noerr"}, 32'(stError[sel]), 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (stDone[sel]) seen = 1'b1;
        end
        check({tag, "_lat"}, n, expN);
        check({tag, "_wren"}, 32'(memWrEn[sel]), 32'd1);
        check({tag, "_wdata"}, memWrData[sel], expData);
        check({tag, "_waddr"}, 32'(memAddr[sel]), 32'(addr[31:2]));
        check({tag, "_be"}, 32'(memByteEn[sel]), 32'(expBe));
        check({tag, "_unstall"}, 32'(stBusy[sel]), 32'd0);
        stReq[sel] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_nwr"}, wrCnt[sel] - wr0, 32'd1);
        check({tag, "_nrd"}, rdCnt[sel] - rd0, expRd);
    endtask

    task automatic errOp(input int sel, input string tag, input logic [31:0] addr, input logic [1:0] size);
        int wr0;
        int rd0;
        wr0 = wrCnt[sel];
        rd0 = rdCnt[sel];
        @(negedge clk);
        stAddr[sel] = addr; stData[sel] = 32'h1234_5678; dataSize[sel] = size; stReq[sel] = 1'b1;
        #1;
        check({tag, "_err"}, 32'(stError[sel]), 32'd1);
        check({tag, "_busy"}, 32'(stBusy[sel]), 32'd0);
        check({tag, "_strobes"}, {30'd0, memRdEn[sel], memWrEn[sel]}, 32'd0);
        @(negedge clk);
        stReq[sel] = 1'b0;
        #1;
        check({tag, "_errclr"}, 32'(stError[sel]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_nacc"}, (wrCnt[sel] - wr0) + (rdCnt[sel] - rd0), 32'd0);
    endtask

    initial begin
        rstN = 1'b0;
        for (int g = 0; g < 2; g++) begin
            stReq[g] = 1'b0; stAddr[g] = '0; stData[g] = '0; dataSize[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_strobes", {28'd0, memRdEn[g], memWrEn[g], stDone[g], stError[g]}, 32'd0);
            check("rst_addr", 32'(memAddr[g]), 32'd0);
            check("rst_wdata", memWrData[g], 32'd0);
`ifdef MEM_STORE_BYTE_EN_EN
            check("rst_be", 32'(memByteEn[g]), 32'd0);
`else
            check("rst_be", 32'(memByteEn[g]), 32'hF);
`endif
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        storeOp(0, "word", 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 1, 32'hDEAD_BEEF, 4'b1111, 0);
        storeOp(1, "word3", 32'h0000_0104, 32'h0BAD_F00D, 2'b00, 1, 32'h0BAD_F00D, 4'b1111, 0);

`ifdef MEM_STORE_BYTE_EN_EN
        storeOp(0, "be_byte3", 32'h0000_0303, 32'h0000_005A, 2'b10, 1, 32'h5A5A_5A5A, 4'b0001, 0);
        storeOp(0, "be_half2", 32'h0000_0206, 32'h0000_BEEF, 2'b01, 1, 32'hBEEF_BEEF, 4'b0011, 0);
        storeOp(1, "be_byte0", 32'h0000_0204, 32'h0000_0077, 2'b10, 1, 32'h7777_7777, 4'b1000, 0);
`else
        preload(4'd0, 32'h1122_3344);
        storeOp(0, "byte2", 32'h0000_0202, 32'hFFFF_FFAB, 2'b10, 3, 32'h1122_AB44, 4'b1111, 1);
        preload(4'd0, 32'h1122_3344);
        storeOp(0, "half0", 32'h0000_0200, 32'h1234_CAFE, 2'b01, 3, 32'hCAFE_3344, 4'b1111, 1);
        storeOp(1, "half0_l3", 32'h0000_0200, 32'h1234_CAFE, 2'b01, 5, 32'hCAFE_3344, 4'b1111, 1);
        preload(4'd0, 32'h1122_3344);
        storeOp(1, "byte3_l3", 32'h0000_0303, 32'h0000_005A, 2'b10, 5, 32'h1122_335A, 4'b1111, 1);
        preload(4'd1, 32'hA0B0_C0D0);
        storeOp(0, "byte0", 32'h0000_0204, 32'h0000_0077, 2'b10, 3, 32'h77B0_C0D0, 4'b1111, 1);
        preload(4'd1, 32'hA0B0_C0D0);
        storeOp(0, "half2", 32'h0000_0206, 32'h0000_BEEF, 2'b01, 3, 32'hA0B0_BEEF, 4'b1111, 1);
`endif

        errOp(0, "err_half1", 32'h0000_0201, 2'b01);
        errOp(0, "err_word2", 32'h0000_0202, 2'b00);
        errOp(1, "err_size3", 32'h0000_0200, 2'b11);

`ifndef MEM_STORE_BYTE_EN_EN
        // Reset during WAIT of a byte store on the latency-3 instance.
        begin
            int wr0;
            wr0 = wrCnt[1];
            @(negedge clk);
            stAddr[1] = 32'h0000_0301; stData[1] = 32'h0000_0011; dataSize[1] = 2'b10; stReq[1] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rstN = 1'b0;
            stReq[1] = 1'b0;
            #1;
            check("rstmid_strobes", {29'd0, memRdEn[1], memWrEn[1], stDone[1]}, 32'd0);
            check("rstmid_addr", 32'(memAddr[1]), 32'd0);
            check("rstmid_wdata", memWrData[1], 32'd0);
            check("rstmid_busy", 32'(stBusy[1]), 32'd0);
            repeat (3) @(negedge clk);
            rstN = 1'b1;
            repeat (4) @(negedge clk);
            check("rstmid_nowr", wrCnt[1] - wr0, 32'd0);
            check("rstmid_wdone", 32'(stDone[1]), 32'd0);
        end
        storeOp(1, "post_rst", 32'h0000_0108, 32'hC001_D00D, 2'b00, 1, 32'hC001_D00D, 4'b1111, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
